// File: rtl/instruction_memory_rw_if.sv
// Bus bundle for instruction_memory_rw: two fetch ports plus the program-load channel.
interface instruction_memory_rw_if #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  rd_req_a;
  logic [WIDTH-1:0]      address_a;
  logic                  rd_ready_a;
  logic                  rvalid_a;
  logic [DATA_WIDTH-1:0] data_a;
  logic                  fault_a;

  logic                  rd_req_b;
  logic [WIDTH-1:0]      address_b;
  logic                  rd_ready_b;
  logic                  rvalid_b;
  logic [DATA_WIDTH-1:0] data_b;
  logic                  fault_b;

  logic                  ld_start;
  logic [WIDTH-1:0]      ld_base;
  logic [WIDTH:0]        ld_len;
  logic                  ld_valid;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  ld_ready;
  logic                  ld_done;
  logic                  ld_err;
  logic                  busy;

  modport master (
    output rd_req_a, address_a, rd_req_b, address_b,
    output ld_start, ld_base, ld_len, ld_valid, ld_data,
    input  rd_ready_a, rvalid_a, data_a, fault_a,
    input  rd_ready_b, rvalid_b, data_b, fault_b,
    input  ld_ready, ld_done, ld_err, busy
  );

  modport slave (
    input  rd_req_a, address_a, rd_req_b, address_b,
    input  ld_start, ld_base, ld_len, ld_valid, ld_data,
    output rd_ready_a, rvalid_a, data_a, fault_a,
    output rd_ready_b, rvalid_b, data_b, fault_b,
    output ld_ready, ld_done, ld_err, busy
  );
endinterface

// File: rtl/instruction_memory_rw.sv
// Dual-read-port instruction memory with a streaming program-load channel.
// Fetches are served in RUN; a load takes exclusive ownership until its DONE cycle.
module instruction_memory_rw #(
  parameter int unsigned           WIDTH      = 16,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           DEPTH      = 8192,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  instruction_memory_rw_if.slave bus
);
  localparam int unsigned     AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WIDTH+1:0] DEPTH_W = (WIDTH + 2)'(DEPTH);

  typedef enum logic [1:0] {StRun, StLoad, StDone} state_e;

  state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [WIDTH-1:0]      ptr_q;
  logic [WIDTH:0]        rem_q;
  logic                  err_q;
  logic                  rvalid_a_q, rvalid_b_q;
  logic                  fault_a_q, fault_b_q;
  logic [DATA_WIDTH-1:0] data_a_q, data_b_q;

  logic                  ok_a, ok_b, accept_a, accept_b;
  logic [WIDTH+1:0]      ld_end;
  logic                  start_run, start_zero, start_bad, start_go;
  logic                  wr_en;

  assign ok_a     = {2'b00, bus.address_a} < DEPTH_W;
  assign ok_b     = {2'b00, bus.address_b} < DEPTH_W;
  assign accept_a = bus.rd_req_a && (state_q == StRun);
  assign accept_b = bus.rd_req_b && (state_q == StRun);

  // End address is formed two bits wider than WIDTH so a large base+len cannot wrap.
  assign ld_end     = {2'b00, bus.ld_base} + {1'b0, bus.ld_len};
  assign start_run  = bus.ld_start && (state_q == StRun);
  assign start_zero = (bus.ld_len == '0);
  assign start_bad  = !start_zero && (ld_end > DEPTH_W);
  assign start_go   = start_run && !start_zero && !start_bad;
  assign wr_en      = (state_q == StLoad) && bus.ld_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (start_run && start_zero) begin
          state_d = StDone;
        end else if (start_go) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (bus.ld_valid && (rem_q == (WIDTH + 1)'(1))) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    bus.rd_ready_a = 1'b0;
    bus.rd_ready_b = 1'b0;
    bus.ld_ready   = 1'b0;
    bus.ld_done    = 1'b0;
    bus.busy       = 1'b0;
    unique case (state_q)
      StRun: begin
        bus.rd_ready_a = 1'b1;
        bus.rd_ready_b = 1'b1;
      end
      StLoad: begin
        bus.ld_ready = 1'b1;
        bus.busy     = 1'b1;
      end
      StDone: begin
        bus.ld_done = 1'b1;
        bus.busy    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      rem_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= start_run && start_bad;
      if (start_go) begin
        ptr_q <= bus.ld_base;
        rem_q <= bus.ld_len;
      end else if (wr_en) begin
        ptr_q <= ptr_q + 1'b1;
        rem_q <= rem_q - 1'b1;
      end
    end
  end

  // Storage has no reset so a reset mid-load keeps the words already written.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[ptr_q[AW-1:0]] <= bus.ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      fault_a_q  <= 1'b0;
      fault_b_q  <= 1'b0;
      data_a_q   <= '0;
      data_b_q   <= '0;
    end else begin
      rvalid_a_q <= accept_a;
      rvalid_b_q <= accept_b;
      if (accept_a) begin
        fault_a_q <= !ok_a;
        data_a_q  <= ok_a ? mem[bus.address_a[AW-1:0]] : NOP_WORD;
      end
      if (accept_b) begin
        fault_b_q <= !ok_b;
        data_b_q  <= ok_b ? mem[bus.address_b[AW-1:0]] : NOP_WORD;
      end
    end
  end

  assign bus.rvalid_a = rvalid_a_q;
  assign bus.rvalid_b = rvalid_b_q;
  assign bus.fault_a  = fault_a_q;
  assign bus.fault_b  = fault_b_q;
  assign bus.data_a   = data_a_q;
  assign bus.data_b   = data_b_q;
  assign bus.ld_err   = err_q;
endmodule

// File: tb/tb_instruction_memory_rw.sv
// Scoreboard bench for instruction_memory_rw: reads push expectations, a monitor pops them.
module tb_instruction_memory_rw;
  localparam int unsigned W     = 16;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 8192;
  localparam logic [31:0] NOP   = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instruction_memory_rw_if #(.WIDTH(W), .DATA_WIDTH(DW)) bus ();

  instruction_memory_rw #(
    .WIDTH(W), .DATA_WIDTH(DW), .DEPTH(DEPTH), .NOP_WORD(NOP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] data;
    logic        fault;
    int          due;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per rvalid and tallies load-side events.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.busy)    busy_cnt++;
      if (bus.ld_done) done_cnt++;
      if (bus.ld_err)  err_cnt++;
    end
    if (bus.rvalid_a) begin
      if (q_a.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL port_a unexpected rvalid: got 1 expected 0 (t=%0t)", $time);
      end else begin
        e = q_a.pop_front();
        chk("port_a data", bus.data_a, e.data);
        chk("port_a fault", 32'(bus.fault_a), 32'(e.fault));
        chk("port_a latency", 32'(cyc), 32'(e.due));
      end
    end
    if (bus.rvalid_b) begin
      if (q_b.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL port_b unexpected rvalid: got 1 expected 0 (t=%0t)", $time);
      end else begin
        e = q_b.pop_front();
        chk("port_b data", bus.data_b, e.data);
        chk("port_b fault", 32'(bus.fault_b), 32'(e.fault));
        chk("port_b latency", 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req_a(input logic [15:0] addr, input logic [31:0] d, input logic f);
    bus.rd_req_a  = 1'b1;
    bus.address_a = addr;
    q_a.push_back('{data: d, fault: f, due: cyc + 1});
  endtask

  task automatic req_b(input logic [15:0] addr, input logic [31:0] d, input logic f);
    bus.rd_req_b  = 1'b1;
    bus.address_b = addr;
    q_b.push_back('{data: d, fault: f, due: cyc + 1});
  endtask

  task automatic idle_reads();
    bus.rd_req_a = 1'b0;
    bus.rd_req_b = 1'b0;
  endtask

  task automatic start_load(input logic [15:0] base, input logic [16:0] len);
    bus.ld_start = 1'b1;
    bus.ld_base  = base;
    bus.ld_len   = len;
    step();
    bus.ld_start = 1'b0;
  endtask

  task automatic put_word(input logic [31:0] d);
    bus.ld_valid = 1'b1;
    bus.ld_data  = d;
    step();
    bus.ld_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, d0, e0;
    bus.rd_req_a = 0; bus.address_a = '0; bus.rd_req_b = 0; bus.address_b = '0;
    bus.ld_start = 0; bus.ld_base = '0; bus.ld_len = '0; bus.ld_valid = 0; bus.ld_data = '0;

    // Reset state
    #12;
    chk("rst rvalid_a", 32'(bus.rvalid_a), 0);
    chk("rst data_a", bus.data_a, 0);
    chk("rst busy", 32'(bus.busy), 0);
    chk("rst ld_ready", 32'(bus.ld_ready), 0);
    chk("rst ld_done", 32'(bus.ld_done), 0);
    chk("rst ld_err", 32'(bus.ld_err), 0);
    chk("rst rd_ready_a", 32'(bus.rd_ready_a), 1);
    rst_n = 1'b1;
    step();

    // Gapped three-word load at 0x10
    b0 = busy_cnt; d0 = done_cnt;
    start_load(16'h0010, 17'd3);
    chk("load busy", 32'(bus.busy), 1);
    chk("load ld_ready", 32'(bus.ld_ready), 1);
    chk("load rd_ready_a", 32'(bus.rd_ready_a), 0);
    put_word(32'hA); step();
    put_word(32'hB); step();
    put_word(32'hC);
    chk("done ld_done", 32'(bus.ld_done), 1);
    chk("done busy", 32'(bus.busy), 1);
    chk("done ld_ready", 32'(bus.ld_ready), 0);
    step();
    chk("post-done busy", 32'(bus.busy), 0);
    chk("post-done ld_done", 32'(bus.ld_done), 0);
    chk("load busy cycles", 32'(busy_cnt - b0), 6);
    chk("load done pulses", 32'(done_cnt - d0), 1);
    req_a(16'h0010, 32'hA, 1'b0); step();
    req_a(16'h0011, 32'hB, 1'b0); step();
    req_a(16'h0012, 32'hC, 1'b0); step();
    idle_reads(); step();

    // Concurrent ports: in-range A, out-of-range B, then same address on both
    req_a(16'h0011, 32'hB, 1'b0);
    req_b(16'h2000, NOP, 1'b1);
    step();
    req_a(16'h0012, 32'hC, 1'b0);
    req_b(16'h0012, 32'hC, 1'b0);
    step();
    idle_reads(); step(); step();
    chk("hold data_a", bus.data_a, 32'hC);
    chk("hold rvalid_a", 32'(bus.rvalid_a), 0);

    // Fill the top two words exactly, then reject an overflowing load
    start_load(16'd8190, 17'd2);
    put_word(32'h1111);
    put_word(32'h2222);
    step();
    e0 = err_cnt;
    start_load(16'd8190, 17'd3);
    chk("overflow ld_err", 32'(bus.ld_err), 1);
    chk("overflow busy", 32'(bus.busy), 0);
    step();
    chk("overflow ld_err pulse", 32'(bus.ld_err), 0);
    chk("overflow err count", 32'(err_cnt - e0), 1);
    req_a(16'd8190, 32'h1111, 1'b0);
    req_b(16'd8191, 32'h2222, 1'b0);
    step();
    idle_reads(); step();

    // Zero-length load goes straight to DONE
    start_load(16'h0005, 17'd0);
    chk("len0 ld_done", 32'(bus.ld_done), 1);
    step();
    chk("len0 back to run", 32'(bus.rd_ready_a), 1);

    // Read alongside ld_start sees old data; reads during LOAD are refused
    req_a(16'h0010, 32'hA, 1'b0);
    start_load(16'h0010, 17'd1);
    bus.rd_req_a  = 1'b1;
    bus.address_a = 16'h0011;
    chk("load-phase rd_ready_a", 32'(bus.rd_ready_a), 0);
    step();
    chk("load-phase no rvalid_a", 32'(bus.rvalid_a), 0);
    put_word(32'h55);
    idle_reads();
    chk("load-phase no rvalid_a 2", 32'(bus.rvalid_a), 0);
    step();
    req_a(16'h0010, 32'h55, 1'b0); step();
    idle_reads(); step();

    // Reset in the middle of a four-word load
    start_load(16'h0020, 17'd4);
    put_word(32'h100);
    put_word(32'h200);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort busy", 32'(bus.busy), 0);
    chk("abort ld_ready", 32'(bus.ld_ready), 0);
    chk("abort data_a", bus.data_a, 0);
    chk("abort data_b", bus.data_b, 0);
    chk("abort rvalid_a", 32'(bus.rvalid_a), 0);
    step();
    #2;
    rst_n = 1'b1;
    step();
    chk("after abort rd_ready_a", 32'(bus.rd_ready_a), 1);
    chk("after abort busy", 32'(bus.busy), 0);
    req_a(16'h0020, 32'h100, 1'b0); step();
    req_a(16'h0021, 32'h200, 1'b0); step();
    idle_reads(); step(); step();

    chk("port_a queue drained", 32'(q_a.size()), 0);
    chk("port_b queue drained", 32'(q_b.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
